// File: rtl/keycode_pkg.sv
// Purpose: shared types and key constants for the keycode event controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keycode_pkg;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } kstate_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  // One queued key event; t sits in the upper two bits of the 10-bit entry.
  typedef struct packed {
    ev_type_t   t;
    logic [7:0] code;
  } key_event_t;

  localparam int EV_W = $bits(key_event_t);

endpackage

// File: rtl/event_fifo.sv
// Purpose: synchronous show-ahead FIFO; head entry is always presented on dout.
// Latency: a push is visible on dout the cycle after the write edge when empty.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: clk, rst (async active-high), push/din write side, pop read side,
//        dout head entry, empty/full status.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keycode_event_ctrl.sv
// Purpose: turns the level keycode from the SoC PIO into PRESS/RELEASE/REPEAT events.
// Latency: 2 clocks from keycode_in change to ev_valid (sample register + FSM push).
// Backpressure: ev_valid/ev_ready; events arriving at a full queue are dropped and flag overflow.
// Ports: Clk, Reset (async active-high), keycode_in, ev_ready, ovf_clear in;
//        ev_valid, ev_code, ev_type (head event), held_code, key_held, overflow out.
module keycode_event_ctrl
  import keycode_pkg::*;
#(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 25
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  input  logic       ev_ready,
  input  logic       ovf_clear,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic [1:0] ev_type,
  output logic [7:0] held_code,
  output logic       key_held,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [7:0]       kc_s;
  logic [7:0]       cur_code;
  logic [7:0]       cur_code_nxt;
  kstate_t          state;
  kstate_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] period_last;
  logic             push;
  key_event_t       push_dat;
  logic             fifo_empty;
  logic             fifo_full;
  logic [EV_W-1:0]  fifo_dout;
  key_event_t       head;
  logic             pop;
  logic             drop;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      kc_s     <= KEY_NONE;
      state    <= IDLE;
      cur_code <= KEY_NONE;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      kc_s     <= keycode_in;
      state    <= state_nxt;
      cur_code <= cur_code_nxt;
      cnt      <= cnt_nxt;
      // A drop in the same cycle as a clear must stay visible.
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  assign period_last = (state == DELAY) ? DELAY_LAST : RATE_LAST;

  always_comb begin
    state_nxt    = state;
    cur_code_nxt = cur_code;
    cnt_nxt      = cnt;
    push         = 1'b0;
    push_dat     = '{t: EV_NONE, code: KEY_NONE};
    case (state)
      IDLE: begin
        if (kc_s != KEY_NONE) begin
          push         = 1'b1;
          push_dat     = '{t: EV_PRESS, code: kc_s};
          cur_code_nxt = kc_s;
          cnt_nxt      = '0;
          state_nxt    = DELAY;
        end
      end
      DELAY, REPEAT: begin
        // Any change, including a direct A->B, releases first; B is pressed from IDLE.
        if (kc_s != cur_code) begin
          push         = 1'b1;
          push_dat     = '{t: EV_RELEASE, code: cur_code};
          cur_code_nxt = KEY_NONE;
          cnt_nxt      = '0;
          state_nxt    = IDLE;
        end else if (cnt == period_last) begin
          // Advances even if the REPEAT is dropped by a full queue.
          push      = 1'b1;
          push_dat  = '{t: EV_REPEAT, code: cur_code};
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop  = !fifo_empty && ev_ready;
  assign drop = push && fifo_full && !pop;

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .din   (push_dat),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Head fields are forced to zero while empty so stale entries never leak out.
  assign head      = fifo_dout;
  assign ev_valid  = !fifo_empty;
  assign ev_code   = fifo_empty ? KEY_NONE : head.code;
  assign ev_type   = fifo_empty ? EV_NONE  : head.t;
  assign held_code = cur_code;
  assign key_held  = (cur_code != KEY_NONE);

endmodule
